fifo_drain_reader: RTL and testbench
====================================

# fifo_drain_reader

Read-side controller that drains the FIFO memory block on behalf of a downstream consumer. It accepts a burst request of N words, issues `trans_read` strobes only when the FIFO reports data, and captures the same-cycle `data_out`. Captured words are presented on a valid/ready stream with a last-beat marker. It sits between the FIFO's read port and any streaming sink, so the FIFO never sees a read while empty and never raises underflow.

## Interface
- `DATA_WIDTH`, 32, word width; must match the FIFO.
- `LEN_W`, 8, width of the burst length field.
- `clk_in`  input  1  clock; all logic on rising edge.
- `sreset`  input  1  synchronous, active-high reset.
- `req_valid`  input  1  burst request valid.
- `req_len`  input  LEN_W  number of words to drain (0 allowed).
- `req_ready`  output  1  high only in IDLE.
- `empty_ind`  input  1  FIFO empty flag.
- `fifo_data`  input  DATA_WIDTH  FIFO `data_out`; valid in the same cycle as `trans_read`.
- `trans_read`  output  1  FIFO read strobe, combinational.
- `m_valid`  output  1  stream data valid.
- `m_data`  output  DATA_WIDTH  stream data.
- `m_last`  output  1  final word of the burst.
- `m_ready`  input  1  sink accepts.
- `done`  output  1  one-cycle burst-complete pulse.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `req_ready`=1.
  - A handshake with `req_len`≠0 loads `remaining`=`req_len` and moves to RUN.
  - A handshake with `req_len`=0 moves directly to DONE.
- **Read strobe:** `trans_read` = (state==RUN) && `remaining`≠0 && !`empty_ind` && (`occ`<2). It has no combinational dependence on `m_ready`.
- **RUN, on each `trans_read`:**
  - Push {`fifo_data`, `remaining`==1} into a 2-entry output buffer.
  - Decrement `remaining`.
  - When `remaining` reaches 0, move to DRAIN.
- **Output buffer:**
  - Depth 2, in order; `occ` is 0..2.
  - A pop occurs when `m_valid` && `m_ready`.
  - Push and pop may occur in the same cycle; `occ` is then unchanged.
  - `m_valid` = `occ`≠0; `m_data`/`m_last` = head entry.
- **DRAIN:** move to DONE on the cycle the `m_last` beat is accepted.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Empty FIFO in RUN:** wait indefinitely, holding `trans_read`=0 and keeping state.
- **Reset mid-burst:** state→IDLE, `occ`=0, `remaining`=0. Buffered words are discarded; the FIFO is not rewound.
- `m_data`/`m_last` are held stable while `m_valid`=1 and `m_ready`=0.

## Timing
- **Reset values:**
  - `req_ready`=1.
  - `trans_read`=0, `m_valid`=0, `m_last`=0, `done`=0.
  - `m_data`=0.
- **Request latency:**
  - Handshake in cycle T → RUN at T+1.
  - First `trans_read` possible at T+1.
  - First `m_valid` at T+2.
- **Throughput:** one word per cycle when the FIFO is non-empty and `m_ready`=1 continuously (steady `occ`=1).
- **Completion:**
  - Last beat accepted in cycle L → `done`=1 at L+1.
  - `req_ready`=1 at L+2.
- **Zero-length request:** handshake at T → `done` at T+1, `req_ready` at T+2, no beats.
- **Back-pressure:** `occ`==2 blocks `trans_read` in that cycle, even if a pop is occurring.

## Configuration
- `FIFO_RD_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` [15:0], cleared by `sreset` and on each accepted request.
  - Increments in every RUN cycle with `empty_ind`=1.
  - Saturates at 16'hFFFF.
- `FIFO_RD_STALL_CNT_EN` not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Basic drain:** FIFO preloaded with 0xA0..0xA3, `req_len`=4, `m_ready`=1 → `trans_read` high for 4 consecutive cycles from T+1. Beats 0xA0..0xA3 arrive on consecutive cycles, `m_last` on 0xA3 only, `done` one cycle after the last beat.
- **Back-pressure:** `req_len`=4, `m_ready` held 0 for 5 cycles → exactly 2 `trans_read` pulses, `m_data` stable at the first word. Releasing `m_ready` delivers all 4 words in order.
- **Empty stall:** FIFO empty, `req_len`=2 → `trans_read` stays 0 and state stays RUN. Writing 2 words into the FIFO completes the burst; the FIFO never flags underflow.
- **Zero length:** `req_len`=0 → no `m_valid`, `done` at T+1, `req_ready` back at T+2.
- **Mid-burst reset:** assert `sreset` after 2 of 4 words → next cycle `m_valid`=0, `req_ready`=1, `done`=0. A new request with `req_len`=1 drains the next FIFO word.
- **Stall counter (macro on):** 10 RUN cycles with `empty_ind`=1 → `stall_cnt`=10. The next accepted request clears it to 0.

Source files
------------

// File: rtl/fifo_drain_reader_if.sv
// Request, FIFO read-port and output stream signals of fifo_drain_reader.
// Optional stall_cnt exists only when FIFO_RD_STALL_CNT_EN is defined.
interface fifo_drain_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8
);
  logic                  req_valid;
  logic [LEN_W-1:0]      req_len;
  logic                  req_ready;
  logic                  empty_ind;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  trans_read;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;
  logic                  done;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  modport master (
    input  req_valid, req_len,
    input  empty_ind, fifo_data,
    input  m_ready,
    output req_ready, trans_read,
    output m_valid, m_data, m_last,
    output done
`ifdef FIFO_RD_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output req_valid, req_len,
    output empty_ind, fifo_data,
    output m_ready,
    input  req_ready, trans_read,
    input  m_valid, m_data, m_last,
    input  done
`ifdef FIFO_RD_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/fifo_drain_reader.sv
// Drains N words from a FIFO read port into a valid/ready stream.
// Define FIFO_RD_STALL_CNT_EN to add the empty-stall counter output.
module fifo_drain_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8
) (
  input  logic                clk_in,
  input  logic                sreset,
  fifo_drain_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] dat0_q, dat0_d;
  logic [DATA_WIDTH-1:0] dat1_q, dat1_d;
  logic                  lst0_q, lst0_d;
  logic                  lst1_q, lst1_d;

  logic req_hs;
  logic rd;
  logic pop;
  logic rd_last;

  assign req_hs  = bus.req_valid && (state_q == IDLE);
  assign rd      = (state_q == RUN)
                && (rem_q != '0)
                && !bus.empty_ind
                && (occ_q < 2'd2);
  assign pop     = (occ_q != 2'd0) && bus.m_ready;
  assign rd_last = (rem_q == LEN_W'(1));

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.trans_read = rd;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = dat0_q;
  assign bus.m_last     = (occ_q != 2'd0) && lst0_q;
  assign bus.done       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          if (bus.req_len != '0) begin
            rem_d   = bus.req_len;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (rd) begin
          rem_d = rem_q - LEN_W'(1);
          if (rd_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && lst0_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd needs occ<2 and pop needs occ>0, so a
  // simultaneous push/pop only happens at occ==1.
  always_comb begin
    occ_d  = occ_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    lst0_d = lst0_q;
    lst1_d = lst1_q;
    unique case (1'b1)
      rd && pop: begin
        dat0_d = bus.fifo_data;
        lst0_d = rd_last;
      end
      rd && !pop: begin
        if (occ_q == 2'd0) begin
          dat0_d = bus.fifo_data;
          lst0_d = rd_last;
        end else begin
          dat1_d = bus.fifo_data;
          lst1_d = rd_last;
        end
        occ_d = occ_q + 2'd1;
      end
      !rd && pop: begin
        dat0_d = dat1_q;
        lst0_d = lst1_q;
        occ_d  = occ_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (sreset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      occ_q   <= 2'd0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      lst0_q  <= 1'b0;
      lst1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      occ_q   <= occ_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      lst0_q  <= lst0_d;
      lst1_q  <= lst1_d;
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (req_hs) begin
      stall_d = 16'h0;
    end else if ((state_q == RUN) && bus.empty_ind
                 && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (sreset) stall_q <= 16'h0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Scoreboard bench for fifo_drain_reader with a behavioural FIFO.
// Stall counter checks run when FIFO_RD_STALL_CNT_EN is defined.
module tb_fifo_drain_reader;

  logic clk = 1'b0;
  logic sreset;

  always #5 clk = ~clk;

  fifo_drain_reader_if #(
    .DATA_WIDTH(32),
    .LEN_W(8)
  ) bus ();

  fifo_drain_reader #(
    .DATA_WIDTH(32),
    .LEN_W(8)
  ) dut (
    .clk_in(clk),
    .sreset(sreset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int trd_cnt = 0;
  int underflow = 0;

  logic [31:0] fq[$];
  logic [32:0] exp_q[$];
  logic        mdl_rd;
  logic [32:0] mon_e;

  // FIFO model: pop after each edge with trans_read
  always begin
    @(posedge clk);
    mdl_rd = bus.trans_read;
    #1;
    if (mdl_rd === 1'b1) begin
      trd_cnt++;
      if (fq.size() == 0) underflow++;
      else void'(fq.pop_front());
    end
    bus.empty_ind = (fq.size() == 0);
    bus.fifo_data = (fq.size() != 0) ? fq[0] : 32'h0;
    @(negedge clk);
    #1;
    bus.empty_ind = (fq.size() == 0);
    bus.fifo_data = (fq.size() != 0) ? fq[0] : 32'h0;
  end

  // stream monitor against the scoreboard
  always @(negedge clk) begin
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_extra got data=%h last=%0b want none",
                 bus.m_data, bus.m_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.m_last, bus.m_data} !== mon_e) begin
          fails++;
          $display("FAIL beat got last=%0b data=%h want last=%0b data=%h",
                   bus.m_last, bus.m_data, mon_e[32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic request(input int len);
    bus.req_valid = 1'b1;
    bus.req_len   = len[7:0];
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      smp();
      if (bus.done === 1'b1) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 32'(i));
      exp_q.push_back({i == n - 1, base + 32'(i)});
    end
  endtask

  task automatic test_reset();
    sreset        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_len   = 8'd0;
    bus.m_ready   = 1'b0;
    repeat (2) step();
    smp();
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_req_ready got %b want 1", bus.req_ready);
    end
    tests++;
    if (bus.trans_read !== 1'b0) begin
      fails++;
      $display("FAIL rst_trans_read got %b want 0", bus.trans_read);
    end
    tests++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0) begin
      fails++;
      $display("FAIL rst_stream got v=%b l=%b want 0 0",
               bus.m_valid, bus.m_last);
    end
    tests++;
    if (bus.done !== 1'b0 || bus.m_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_done_data got done=%b data=%h want 0 0",
               bus.done, bus.m_data);
    end
    step();
    sreset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    push_words(32'hA0, 4);
    bus.m_ready = 1'b1;
    smp();
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_req_ready got %b want 1", bus.req_ready);
    end
    request(4);
    for (int k = 1; k <= 6; k++) begin
      smp();
      tests++;
      if (bus.trans_read !== (k <= 4)) begin
        fails++;
        $display("FAIL basic_trans_read T+%0d got %b want %b",
                 k, bus.trans_read, (k <= 4));
      end
      tests++;
      if (bus.done !== (k == 6)) begin
        fails++;
        $display("FAIL basic_done T+%0d got %b want %b",
                 k, bus.done, (k == 6));
      end
      step();
    end
    smp();
    tests++;
    if (bus.req_ready !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_end got rdy=%b left=%0d want 1 0",
               bus.req_ready, exp_q.size());
    end
    step();
  endtask

  task automatic test_backpressure();
    int t0, n;
    bit ok;
    push_words(32'hB0, 4);
    bus.m_ready = 1'b0;
    smp();
    t0 = trd_cnt;
    request(4);
    for (int k = 1; k <= 5; k++) begin
      smp();
      if (k >= 2) begin
        tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hB0) begin
          fails++;
          $display("FAIL bp_hold T+%0d got v=%b d=%h want 1 b0",
                   k, bus.m_valid, bus.m_data);
        end
      end
      step();
    end
    tests++;
    if (trd_cnt - t0 != 2) begin
      fails++;
      $display("FAIL bp_reads got %0d want 2", trd_cnt - t0);
    end
    bus.m_ready = 1'b1;
    wait_done(20, n, ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_done got ok=%0b left=%0d want 1 0",
               ok, exp_q.size());
    end
    step();
  endtask

  task automatic test_empty_stall();
    int t0, n, bad;
    bit ok;
    bus.m_ready = 1'b1;
    bad = 0;
    smp();
    t0 = trd_cnt;
    request(2);
    for (int k = 1; k <= 8; k++) begin
      smp();
      if (bus.trans_read !== 1'b0 || bus.req_ready !== 1'b0 ||
          bus.done !== 1'b0 || bus.m_valid !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    push_words(32'hC0, 2);
    wait_done(20, n, ok);
    tests++;
    if (!ok || exp_q.size() != 0 || trd_cnt - t0 != 2) begin
      fails++;
      $display("FAIL stall_done got ok=%0b left=%0d rd=%0d want 1 0 2",
               ok, exp_q.size(), trd_cnt - t0);
    end
    tests++;
    if (underflow != 0) begin
      fails++;
      $display("FAIL stall_underflow got %0d want 0", underflow);
    end
    step();
  endtask

  task automatic test_zero_len();
    smp();
    request(0);
    smp();
    tests++;
    if (bus.done !== 1'b1 || bus.m_valid !== 1'b0 ||
        bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_t1 got d=%b v=%b r=%b want 1 0 0",
               bus.done, bus.m_valid, bus.req_ready);
    end
    step();
    smp();
    tests++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL zero_t2 got r=%b d=%b want 1 0",
               bus.req_ready, bus.done);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int t0, n;
    bit ok;
    push_words(32'hD0, 4);
    bus.m_ready = 1'b0;
    smp();
    t0 = trd_cnt;
    request(4);
    repeat (3) step();
    tests++;
    if (trd_cnt - t0 != 2) begin
      fails++;
      $display("FAIL mrst_reads got %0d want 2", trd_cnt - t0);
    end
    sreset = 1'b1;
    exp_q.delete();
    step();
    sreset = 1'b0;
    smp();
    tests++;
    if (bus.m_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.done !== 1'b0) begin
      fails++;
      $display("FAIL mrst_state got v=%b r=%b d=%b want 0 1 0",
               bus.m_valid, bus.req_ready, bus.done);
    end
    exp_q.push_back({1'b1, 32'hD2});
    bus.m_ready = 1'b1;
    request(1);
    wait_done(20, n, ok);
    tests++;
    if (!ok || exp_q.size() != 0 || fq.size() != 1) begin
      fails++;
      $display("FAIL mrst_next got ok=%0b left=%0d fifo=%0d want 1 0 1",
               ok, exp_q.size(), fq.size());
    end
    step();
    fq.delete();
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    push_words(32'hE0, 6);
    bus.m_ready = 1'b1;
    smp();
    request(6);
    wait_done(30, n, ok);
    tests++;
    if (!ok || n != 7 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_latency got ok=%0b n=%0d left=%0d want 1 7 0",
               ok, n, exp_q.size());
    end
    step();
  endtask

`ifdef FIFO_RD_STALL_CNT_EN
  task automatic test_stall_cnt();
    int n;
    bit ok;
    bus.m_ready = 1'b1;
    smp();
    request(2);
    repeat (10) step();
    smp();
    tests++;
    if (bus.stall_cnt !== 16'd10) begin
      fails++;
      $display("FAIL scnt_ten got %0d want 10", bus.stall_cnt);
    end
    step();
    push_words(32'hF0, 2);
    wait_done(20, n, ok);
    step();
    smp();
    request(0);
    smp();
    tests++;
    if (!ok || bus.stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL scnt_clear got ok=%0b cnt=%0d want 1 0",
               ok, bus.stall_cnt);
    end
    step();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_mid_reset();
    test_back_to_back();
`ifdef FIFO_RD_STALL_CNT_EN
    test_stall_cnt();
`endif
    tests++;
    if (underflow != 0) begin
      fails++;
      $display("FAIL final_underflow got %0d want 0", underflow);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
